// File: rtl/demux_pkg.sv
// Shared constants and types for the 4-way demux feeder.
package demux_pkg;
  localparam int NUM_CH = 4;
  localparam int DEST_W = 2;

  typedef logic [DEST_W-1:0] dest_t;

  function automatic dest_t rr_next(input dest_t p);
    return p + dest_t'(1);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with exact occupancy count and synchronous clear; reset is sync active-low.
module sync_fifo #(
  parameter  int W     = 6,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (rst_n && !clr && do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/demux_dispatch.sv
// Buffers stream words and issues one registered (sel, data, valid) per cycle to the demux.
// Optional DISPATCH_STATS_EN adds per-channel saturating dispatch counters on stat_cnt.
module demux_dispatch
  import demux_pkg::*;
#(
  parameter  int W     = 4,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              rr_mode,
  input  logic              flush,
  input  logic [NUM_CH-1:0] chan_ready,
  output logic [DEST_W-1:0] out_sel,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  output logic [CW-1:0]     fifo_count
`ifdef DISPATCH_STATS_EN
  ,
  output logic [NUM_CH*8-1:0] stat_cnt
`endif
);
  typedef struct packed {
    dest_t          dest;
    logic [W-1:0]   data;
  } entry_t;

  entry_t wr_e, rd_e;
  logic   full, empty, push, disp;
  dest_t  rr_ptr, eff_dest;

  assign wr_e     = '{dest: in_dest, data: in_data};
  assign in_ready = rst_n && !full;
  assign push     = in_valid && in_ready;
  assign eff_dest = rr_mode ? rr_ptr : rd_e.dest;
  assign disp     = !empty && chan_ready[eff_dest] && !flush;

  sync_fifo #(.W(W + DEST_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push),
    .pop   (disp),
    .wdata (wr_e),
    .rdata (rd_e),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // rr_ptr only moves on a round-robin dispatch, so flush and mode changes keep it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sel   <= '0;
      out_data  <= '0;
      rr_ptr    <= '0;
    end else begin
      out_valid <= disp;
      if (disp) begin
        out_sel  <= eff_dest;
        out_data <= rd_e.data;
        if (rr_mode) rr_ptr <= rr_next(rr_ptr);
      end
    end
  end

`ifdef DISPATCH_STATS_EN
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_stat
    logic [7:0] cnt;
    always_ff @(posedge clk) begin
      if (!rst_n || flush)
        cnt <= '0;
      else if (disp && eff_dest == dest_t'(ch) && cnt != 8'hFF)
        cnt <= cnt + 8'd1;
    end
    assign stat_cnt[ch*8 +: 8] = cnt;
  end
`endif
endmodule

// File: tb/tb_demux_dispatch.sv
// Directed table-driven bench for demux_dispatch plus hand-written reset and stats sequences.
module tb_demux_dispatch;
  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, rr_mode, flush, out_valid;
  logic [3:0] in_data, chan_ready, out_data;
  logic [1:0] in_dest, out_sel;
  logic [2:0] fifo_count;
`ifdef DISPATCH_STATS_EN
  logic [31:0] stat_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux_dispatch #(.W(4), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .rr_mode    (rr_mode),
    .flush      (flush),
    .chan_ready (chan_ready),
    .out_sel    (out_sel),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .fifo_count (fifo_count)
`ifdef DISPATCH_STATS_EN
    ,
    .stat_cnt   (stat_cnt)
`endif
  );

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic [1:0] dst;
    logic       rr;
    logic       fl;
    logic [3:0] cr;
    logic       ir;
    logic       ov;
    logic [1:0] os;
    logic [3:0] od;
    logic [2:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [3:0] d, input logic [1:0] dst,
                              input logic rr, input logic fl, input logic [3:0] cr,
                              input logic ir, input logic ov, input logic [1:0] os,
                              input logic [3:0] od, input logic [2:0] cnt);
    vec_t r;
    r.v = v; r.d = d; r.dst = dst; r.rr = rr; r.fl = fl; r.cr = cr;
    r.ir = ir; r.ov = ov; r.os = os; r.od = od; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic [1:0] dst,
                       input logic rr, input logic fl, input logic [3:0] cr);
    in_valid = v; in_data = d; in_dest = dst; rr_mode = rr; flush = fl; chan_ready = cr;
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [1:0] os,
                         input logic [3:0] od, input logic [2:0] cnt);
    chk({tag, ".out_valid"},  32'(out_valid),  32'(ov));
    chk({tag, ".out_sel"},    32'(out_sel),    32'(os));
    chk({tag, ".out_data"},   32'(out_data),   32'(od));
    chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(cnt));
  endtask

  initial begin
    // Tagged order
    tbl.push_back(mk(1, 4'hA, 2, 0, 0, 4'hF, 1, 0, 0, 4'h0, 1));
    tbl.push_back(mk(1, 4'h5, 0, 0, 0, 4'hF, 1, 1, 2, 4'hA, 1));
    tbl.push_back(mk(1, 4'hF, 3, 0, 0, 4'hF, 1, 1, 0, 4'h5, 1));
    tbl.push_back(mk(0, 4'h0, 0, 0, 0, 4'hF, 1, 1, 3, 4'hF, 0));
    tbl.push_back(mk(0, 4'h0, 0, 0, 0, 4'hF, 1, 0, 3, 4'hF, 0));
    // Head blocking
    tbl.push_back(mk(1, 4'h1, 0, 0, 0, 4'hE, 1, 0, 3, 4'hF, 1));
    tbl.push_back(mk(1, 4'h2, 1, 0, 0, 4'hE, 1, 0, 3, 4'hF, 2));
    tbl.push_back(mk(0, 4'h0, 0, 0, 0, 4'hE, 1, 0, 3, 4'hF, 2));
    tbl.push_back(mk(0, 4'h0, 0, 0, 0, 4'hF, 1, 1, 0, 4'h1, 1));
    tbl.push_back(mk(0, 4'h0, 0, 0, 0, 4'hF, 1, 1, 1, 4'h2, 0));
    tbl.push_back(mk(0, 4'h0, 0, 0, 0, 4'h0, 1, 0, 1, 4'h2, 0));
    // Full: 4 accepted, 5th held off, in_ready stays low on the draining cycle
    tbl.push_back(mk(1, 4'h3, 0, 0, 0, 4'h0, 1, 0, 1, 4'h2, 1));
    tbl.push_back(mk(1, 4'h4, 0, 0, 0, 4'h0, 1, 0, 1, 4'h2, 2));
    tbl.push_back(mk(1, 4'h5, 0, 0, 0, 4'h0, 1, 0, 1, 4'h2, 3));
    tbl.push_back(mk(1, 4'h6, 0, 0, 0, 4'h0, 1, 0, 1, 4'h2, 4));
    tbl.push_back(mk(1, 4'h7, 0, 0, 0, 4'h0, 0, 0, 1, 4'h2, 4));
    tbl.push_back(mk(0, 4'h7, 0, 0, 0, 4'hF, 0, 1, 0, 4'h3, 3));
    tbl.push_back(mk(0, 4'h0, 0, 0, 0, 4'hF, 1, 1, 0, 4'h4, 2));
    tbl.push_back(mk(0, 4'h0, 0, 0, 0, 4'hF, 1, 1, 0, 4'h5, 1));
    tbl.push_back(mk(0, 4'h0, 0, 0, 0, 4'hF, 1, 1, 0, 4'h6, 0));
    tbl.push_back(mk(0, 4'h0, 0, 0, 0, 4'hF, 1, 0, 0, 4'h6, 0));
    // Round-robin ignores the tag
    tbl.push_back(mk(1, 4'h8, 0, 1, 0, 4'hF, 1, 0, 0, 4'h6, 1));
    tbl.push_back(mk(1, 4'h9, 0, 1, 0, 4'hF, 1, 1, 0, 4'h8, 1));
    tbl.push_back(mk(1, 4'hA, 0, 1, 0, 4'hF, 1, 1, 1, 4'h9, 1));
    tbl.push_back(mk(1, 4'hB, 0, 1, 0, 4'hF, 1, 1, 2, 4'hA, 1));
    tbl.push_back(mk(1, 4'hC, 0, 1, 0, 4'hF, 1, 1, 3, 4'hB, 1));
    tbl.push_back(mk(0, 4'h0, 0, 1, 0, 4'hF, 1, 1, 0, 4'hC, 0));
    tbl.push_back(mk(0, 4'h0, 0, 1, 0, 4'hF, 1, 0, 0, 4'hC, 0));
    // Flush with 3 buffered plus a same-cycle push; rr_ptr (now 1) survives
    tbl.push_back(mk(1, 4'h1, 3, 1, 0, 4'h0, 1, 0, 0, 4'hC, 1));
    tbl.push_back(mk(1, 4'h2, 3, 1, 0, 4'h0, 1, 0, 0, 4'hC, 2));
    tbl.push_back(mk(1, 4'h3, 3, 1, 0, 4'h0, 1, 0, 0, 4'hC, 3));
    tbl.push_back(mk(1, 4'h4, 3, 1, 1, 4'hF, 1, 0, 0, 4'hC, 0));
    tbl.push_back(mk(0, 4'h0, 3, 1, 0, 4'hF, 1, 0, 0, 4'hC, 0));
    tbl.push_back(mk(1, 4'h5, 3, 1, 0, 4'hF, 1, 0, 0, 4'hC, 1));
    tbl.push_back(mk(0, 4'h0, 3, 1, 0, 4'hF, 1, 1, 1, 4'h5, 0));
    // Mode switches: tag used, then rr_ptr resumes at 2
    tbl.push_back(mk(1, 4'h6, 3, 0, 0, 4'h0, 1, 0, 1, 4'h5, 1));
    tbl.push_back(mk(0, 4'h0, 0, 0, 0, 4'hF, 1, 1, 3, 4'h6, 0));
    tbl.push_back(mk(1, 4'h7, 0, 1, 0, 4'h0, 1, 0, 3, 4'h6, 1));
    tbl.push_back(mk(0, 4'h0, 0, 1, 0, 4'hF, 1, 1, 2, 4'h7, 0));

    // Reset state; pushes during reset are ignored
    rst_n = 1'b0;
    drive(1, 4'h9, 1, 0, 0, 4'hF);
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'(0));
    tick();
    tick();
    chk_out("rst", 0, 0, 4'h0, 0);
    drive(0, 4'h0, 0, 0, 0, 4'hF);
    rst_n = 1'b1;
    #1;
    chk("rst_rel.in_ready", 32'(in_ready), 32'(1));

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].dst, tbl[i].rr, tbl[i].fl, tbl[i].cr);
      #1;
      chk($sformatf("row%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
      tick();
      chk_out($sformatf("row%0d", i), tbl[i].ov, tbl[i].os, tbl[i].od, tbl[i].cnt);
    end

    // Reset mid-dispatch: buffered word lost, outputs cleared, rr_ptr back to 0
    drive(1, 4'h9, 2, 0, 0, 4'hF);
    tick();
    drive(1, 4'hA, 1, 0, 0, 4'hF);
    tick();
    chk_out("pre_rst", 1, 2, 4'h9, 1);
    rst_n = 1'b0;
    drive(1, 4'hB, 1, 0, 0, 4'hF);
    #1;
    chk("mid_rst.in_ready", 32'(in_ready), 32'(0));
    tick();
    chk_out("mid_rst", 0, 0, 4'h0, 0);
    tick();
    rst_n = 1'b1;
    drive(0, 4'h0, 0, 1, 0, 4'hF);
    tick();
    chk_out("post_rst", 0, 0, 4'h0, 0);
    drive(1, 4'hC, 3, 1, 0, 4'hF);
    tick();
    drive(0, 4'h0, 0, 1, 0, 4'hF);
    tick();
    chk_out("post_rst_rr", 1, 0, 4'hC, 0);

`ifdef DISPATCH_STATS_EN
    drive(0, 4'h0, 0, 0, 1, 4'hF);
    tick();
    chk("stat.clear", stat_cnt, 32'h0);
    for (int k = 0; k < 300; k++) begin
      drive(1, 4'(k), 1, 0, 0, 4'hF);
      tick();
    end
    drive(0, 4'h0, 0, 0, 0, 4'hF);
    tick();
    tick();
    chk("stat.sat", stat_cnt, 32'h0000_FF00);
    drive(0, 4'h0, 0, 0, 1, 4'hF);
    tick();
    chk("stat.flush", stat_cnt, 32'h0);
    drive(0, 4'h0, 0, 0, 0, 4'hF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
